// File: rtl/mul8_seq_ctrl_if.sv
// rtl/mul8_seq_ctrl_if.sv - operand/result handshake bundle for mul8_seq_ctrl
//
// Signals:
//   in_valid  : operand pair offered (master -> slave)
//   in_ready  : slave accepts operands this cycle (slave -> master)
//   in_a      : 8-bit unsigned multiplicand (master -> slave)
//   in_b      : 8-bit unsigned multiplier (master -> slave)
//   out_valid : result available (slave -> master)
//   out_ready : master takes result this cycle (master -> slave)
//   out_p     : 16-bit unsigned product (slave -> master)
// Modports: master (operand source / result sink), slave (the controller).

interface mul8_seq_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_a;
    logic [7:0]  in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/mul8_seq_ctrl.sv
// rtl/mul8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over a shared 4x4 multiplier
//
// Ports:
//   clk      : single clock, all state updates on the rising edge
//   rst_n    : asynchronous active-low reset
//   io       : mul8_seq_ctrl_if.slave operand/result handshake
//   busy     : high whenever the controller is not idle
//   mul_lhs  : nibble driven to the shared 4x4 multiplier
//   mul_rhs  : nibble driven to the shared 4x4 multiplier
//   mul_prod : combinational mul_lhs*mul_rhs returned by the shared multiplier
//
// Configuration macro:
//   MUL_SEQ_EARLY_EXIT_EN : when defined, an operation whose multiplier has a
//                           zero upper nibble finishes after two steps instead
//                           of four; the product is the same either way.

module mul8_seq_ctrl (
    input  logic               clk,
    input  logic               rst_n,
    mul8_seq_ctrl_if.slave     io,
    output logic               busy,
    output logic [3:0]         mul_lhs,
    output logic [3:0]         mul_rhs,
    input  logic [7:0]         mul_prod
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [1:0]  k;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] acc;
    logic [15:0] addend;

    // Partial-product schedule: low x low, high x low, low x high, high x high.
    // The addend is the shared multiplier result placed at its nibble weight.
    always_comb begin
        mul_lhs = 4'h0;
        mul_rhs = 4'h0;
        addend  = 16'h0000;
        if (state == MUL) begin
            case (k)
                2'd0: begin
                    mul_lhs = a[3:0];
                    mul_rhs = b[3:0];
                    addend  = {8'h00, mul_prod};
                end
                2'd1: begin
                    mul_lhs = a[7:4];
                    mul_rhs = b[3:0];
                    addend  = {4'h0, mul_prod, 4'h0};
                end
                2'd2: begin
                    mul_lhs = a[3:0];
                    mul_rhs = b[7:4];
                    addend  = {4'h0, mul_prod, 4'h0};
                end
                default: begin
                    mul_lhs = a[7:4];
                    mul_rhs = b[7:4];
                    addend  = {mul_prod, 8'h00};
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= 2'd0;
            a     <= 8'h00;
            b     <= 8'h00;
            acc   <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    if (io.in_valid) begin
                        a     <= io.in_a;
                        b     <= io.in_b;
                        acc   <= 16'h0000;
                        k     <= 2'd0;
                        state <= MUL;
                    end
                end
                MUL: begin
                    // Worst case sum is 0xFE01, so the 16-bit add never wraps.
                    acc <= acc + addend;
                    k   <= k + 2'd1;
                    if (k == 2'd3) begin
                        state <= DONE;
                    end
`ifdef MUL_SEQ_EARLY_EXIT_EN
                    // Steps 2-3 multiply by b[7:4]; when it is zero they add nothing.
                    else if (k == 2'd1 && b[7:4] == 4'h0) begin
                        state <= DONE;
                    end
`else
`endif
                end
                DONE: begin
                    if (io.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign io.in_ready  = (state == IDLE);
    assign io.out_valid = (state == DONE);
    assign io.out_p     = acc;
    assign busy         = (state != IDLE);

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb/tb_mul8_seq_ctrl.sv - scoreboard testbench for mul8_seq_ctrl

module tb_mul8_seq_ctrl;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [3:0] mul_lhs;
    logic [3:0] mul_rhs;
    logic [7:0] mul_prod;

    mul8_seq_ctrl_if bus ();

    mul8_seq_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io       (bus),
        .busy     (busy),
        .mul_lhs  (mul_lhs),
        .mul_rhs  (mul_rhs),
        .mul_prod (mul_prod)
    );

    // Shared 4x4 multiplier that lives outside the controller.
    assign mul_prod = {4'h0, mul_lhs} * {4'h0, mul_rhs};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    logic [15:0] sb[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_in_ready"},  {31'b0, bus.in_ready},  32'd1);
        check_eq({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check_eq({tag, "_out_p"},     {16'b0, bus.out_p},     32'd0);
        check_eq({tag, "_busy"},      {31'b0, busy},          32'd0);
        check_eq({tag, "_mul_lhs"},   {28'b0, mul_lhs},       32'd0);
        check_eq({tag, "_mul_rhs"},   {28'b0, mul_rhs},       32'd0);
    endtask

    function automatic int latency_for(input logic [7:0] b);
`ifdef MUL_SEQ_EARLY_EXIT_EN
        if (b[7:4] == 4'h0) return 2;
`endif
        return 4;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] p, input int hold);
        int          lat;
        logic [3:0]  el;
        logic [3:0]  er;
        logic [15:0] exp_p;
        lat = latency_for(b);
        check_eq("in_ready_before", {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        sb.push_back(p);
        @(negedge clk);
        // Keep offering different operands; the controller must ignore them.
        bus.in_a = ~a;
        bus.in_b = b ^ 8'h5A;
        for (int s = 0; s < lat; s++) begin
            case (s)
                0:       begin el = a[3:0]; er = b[3:0]; end
                1:       begin el = a[7:4]; er = b[3:0]; end
                2:       begin el = a[3:0]; er = b[7:4]; end
                default: begin el = a[7:4]; er = b[7:4]; end
            endcase
            check_eq($sformatf("step%0d_lhs", s), {28'b0, mul_lhs}, {28'b0, el});
            check_eq($sformatf("step%0d_rhs", s), {28'b0, mul_rhs}, {28'b0, er});
            check_eq($sformatf("step%0d_busy", s), {31'b0, busy}, 32'd1);
            check_eq($sformatf("step%0d_in_ready", s), {31'b0, bus.in_ready}, 32'd0);
            check_eq($sformatf("step%0d_out_valid", s), {31'b0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end
        check_eq("done_out_valid", {31'b0, bus.out_valid}, 32'd1);
        check_eq("done_mul_lhs", {28'b0, mul_lhs}, 32'd0);
        check_eq("done_mul_rhs", {28'b0, mul_rhs}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq($sformatf("hold%0d_out_valid", h), {31'b0, bus.out_valid}, 32'd1);
            check_eq($sformatf("hold%0d_in_ready", h), {31'b0, bus.in_ready}, 32'd0);
            check_eq($sformatf("hold%0d_out_p", h), {16'b0, bus.out_p}, {16'b0, p});
        end
        bus.out_ready = 1'b1;
        if (sb.size() > 0) begin
            exp_p = sb.pop_front();
            check_eq($sformatf("out_p_%02h_x_%02h", a, b), {16'b0, bus.out_p}, {16'b0, exp_p});
        end
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check_eq("ret_in_ready", {31'b0, bus.in_ready}, 32'd1);
        check_eq("ret_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check_eq("ret_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        int          hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        n_vec = 0;
        n_err = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 8'h00;
        bus.in_b      = 8'h00;
        bus.out_ready = 1'b0;

        vecs[0] = '{8'h0C, 8'h0D, 16'h009C, 0};
        vecs[1] = '{8'hFF, 8'hFF, 16'hFE01, 0};
        vecs[2] = '{8'h3C, 8'h5A, 16'h1518, 10};
        vecs[3] = '{8'hAB, 8'h07, 16'h04AD, 2};
        vecs[4] = '{8'h00, 8'hAB, 16'h0000, 0};
        vecs[5] = '{8'h02, 8'h03, 16'h0006, 1};

        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].hold);
        end

        // Abort 0xAB x 0xCD at step 2 with an asynchronous reset pulse.
        bus.in_valid = 1'b1;
        bus.in_a     = 8'hAB;
        bus.in_b     = 8'hCD;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("abort_step2_lhs", {28'b0, mul_lhs}, 32'hB);
        check_eq("abort_step2_rhs", {28'b0, mul_rhs}, 32'hC);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check_eq($sformatf("abort_no_result%0d", c), {31'b0, bus.out_valid}, 32'd0);
        end
        run_op(8'h02, 8'h03, 16'h0006, 0);

        for (int i = 0; i < 6; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i == 0) rb[7:4] = 4'h0;
            run_op(ra, rb, 16'(ra) * 16'(rb), i % 3);
        end

        check_eq("scoreboard_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
